// File: rtl/sdram_pll_reset_sequencer_pkg.sv
// Purpose: shared types and widths for the SDRAM/camera PLL reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // Larger of two parameter values, used to size the shared counters.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_pll_reset_sequencer_sync_2ff.sv
// Purpose: 1-bit two-flop synchronizer for a signal asynchronous to refclk.
// Latency: an input change appears on q after two refclk edges.
// Backpressure: none; free-running.
module sync_2ff (
    input  logic refclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages clear on synchronous reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sdram_pll_reset_sequencer.sv
// Purpose: pulse PLL reset, debounce lock, release SDRAM then camera/VGA resets; retry and flag failure.
// Latency: pll_locked reaches the FSM 2 cycles late; outputs are Moore-decoded from the state register.
// Backpressure: none; relock_req is a single-cycle request accepted in any state.
module sdram_pll_reset_sequencer
    import sdram_pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES      = 256,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sdram_rst,
    output logic               cam_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  lock_loss_cnt
);

    localparam int unsigned CNT_MAX = max2(max2(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                           max2(LOCK_STABLE_CYCLES, STAGGER_CYCLES));
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    // Terminal counts: each phase ends on the cycle its counter holds N-1.
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    state_t             state_q;
    state_t             state_d;
    logic               lock_s;
    logic [CNT_W-1:0]   phase_cnt;   // pulse / stable-run / stagger, cleared on every state change
    logic [CNT_W-1:0]   tmo_cnt;     // spans WAIT_LOCK and STABLE so a chattering lock still expires
    logic [RETRY_W-1:0] retry_q;
    logic [LOSS_W-1:0]  loss_q;
    logic [RETRY_W-1:0] retry_inc;
    logic               tmo_hit;
    logic               loss_hit;
    logic               in_acquire_q;
    logic               in_acquire_d;

    sync_2ff u_lock_sync (
        .refclk (refclk),
        .rst    (rst),
        .d      (pll_locked),
        .q      (lock_s)
    );

    assign retry_inc    = retry_q + 1'b1;
    assign in_acquire_q = (state_q == WAIT_LOCK) || (state_q == STABLE);
    assign in_acquire_d = (state_d == WAIT_LOCK) || (state_d == STABLE);

    // State register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= RESET_PLL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: relock_req > lock loss > timeout > phase counter expiry.
    always_comb begin
        state_d  = state_q;
        tmo_hit  = 1'b0;
        loss_hit = 1'b0;
        if (relock_req) begin
            state_d = RESET_PLL;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (phase_cnt == PULSE_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (tmo_cnt == TMO_LAST) begin
                        tmo_hit = 1'b1;
                        state_d = (retry_inc == RETRY_LIMIT) ? FAIL : RESET_PLL;
                    end else if (lock_s) begin
                        state_d = STABLE;
                    end
                end
                STABLE: begin
                    if (tmo_cnt == TMO_LAST) begin
                        tmo_hit = 1'b1;
                        state_d = (retry_inc == RETRY_LIMIT) ? FAIL : RESET_PLL;
                    end else if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (phase_cnt == STABLE_LAST) begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        loss_hit = 1'b1;
                        state_d  = RESET_PLL;
                    end else if (phase_cnt == STAGGER_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        loss_hit = 1'b1;
                        state_d  = RESET_PLL;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RESET_PLL;
                end
            endcase
        end
    end

    // Counters, retry tally and saturating lock-loss tally.
    always_ff @(posedge refclk) begin
        if (rst) begin
            phase_cnt <= '0;
            tmo_cnt   <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
        end else begin
            if (relock_req || (state_d != state_q)) begin
                phase_cnt <= '0;
            end else if ((state_q == RESET_PLL) || (state_q == STABLE) || (state_q == RELEASE)) begin
                phase_cnt <= phase_cnt + 1'b1;
            end

            if (!relock_req && in_acquire_q && in_acquire_d) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (relock_req) begin
                retry_q <= '0;
            end else if (tmo_hit) begin
                retry_q <= retry_inc;
            end else if ((state_d == RUN) && (state_q != RUN)) begin
                retry_q <= '0;
            end

            if (loss_hit && (loss_q != '1)) begin
                loss_q <= loss_q + 1'b1;
            end
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        pll_rst   = 1'b1;
        sdram_rst = 1'b1;
        cam_rst   = 1'b1;
        ready     = 1'b0;
        fail      = 1'b0;
        case (state_q)
            WAIT_LOCK, STABLE: begin
                pll_rst = 1'b0;
            end
            RELEASE: begin
                pll_rst   = 1'b0;
                sdram_rst = 1'b0;
            end
            RUN: begin
                pll_rst   = 1'b0;
                sdram_rst = 1'b0;
                cam_rst   = 1'b0;
                ready     = 1'b1;
            end
            FAIL: begin
                fail = 1'b1;
            end
            default: begin
                pll_rst = 1'b1;
            end
        endcase
    end

    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: doc/sdram_pll_reset_sequencer.md
Name: sdram_pll_reset_sequencer

Overview:
- Sequences bring-up of the 4-output SDRAM/camera PLL: 50 MHz ref, two 100 MHz outputs (one at 7500 ps phase), two 25 MHz outputs.
- Pulses the PLL reset, waits for a debounced lock, then releases downstream resets in a staggered order: SDRAM controller first, then camera/VGA.
- Runs on the PLL reference clock. Recovers from loss of lock, retries failed acquisitions, and flags permanent failure.

Parameters:
- RST_PULSE_CYCLES, 16: cycles `pll_rst` is held high per attempt (must be ≥1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles allowed per attempt to reach stable lock (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- STAGGER_CYCLES, 256: cycles between `sdram_rst` release and `cam_rst` release.
- MAX_RETRIES, 3: failed attempts before entering FAIL (range 1..15).

Ports:
- refclk  in  1  50 MHz reference clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- pll_locked  in  1  PLL lock, asynchronous to `refclk`.
- relock_req  in  1  single-cycle request to restart the PLL and clear retries.
- pll_rst  out  1  drives the PLL `rst`.
- sdram_rst  out  1  SDRAM controller reset, active-high.
- cam_rst  out  1  camera/VGA-domain reset, active-high.
- ready  out  1  all clocks valid and all resets released.
- fail  out  1  retries exhausted.
- retry_cnt  out  4  failed attempts since last clear.
- lock_loss_cnt  out  8  saturating count of lock losses after release.

Behaviour:
- Reset: already decided — one clock (`refclk`); `rst` is synchronous, active-high. All state resets on a rising edge of `refclk` with `rst`=1.
- Reset values: state=RESET_PLL, `pll_rst`=1, `sdram_rst`=1, `cam_rst`=1, `ready`=0, `fail`=0, `retry_cnt`=0, `lock_loss_cnt`=0, all counters=0, synchronizer flops=0.
- Lock synchronizer:
  - `pll_locked` passes through a 2-flop synchronizer to give `lock_s`.
  - An input change is visible in `lock_s` exactly 2 cycles later.
- Outputs are Moore-decoded from the state register only; no combinational path from inputs to outputs.
- Cycle 0 is the first edge with `rst`=0.
- States:
  - RESET_PLL:
    - Outputs: `pll_rst`=1, `sdram_rst`=1, `cam_rst`=1, `ready`=0.
    - Stays exactly RST_PULSE_CYCLES cycles, then goes to WAIT_LOCK.
    - The timeout counter is cleared on entry.
  - WAIT_LOCK:
    - Outputs: `pll_rst`=0; the downstream resets stay high.
    - The timeout counter increments every cycle.
    - `lock_s`=1 → STABLE, with the stable counter cleared.
  - STABLE:
    - The timeout counter keeps running.
    - `lock_s`=0 → WAIT_LOCK. The timeout counter is not cleared, so a chattering lock still times out.
    - LOCK_STABLE_CYCLES consecutive cycles with `lock_s`=1 → RELEASE.
  - Timeout (WAIT_LOCK or STABLE):
    - Triggers when the timeout counter reaches LOCK_TIMEOUT_CYCLES-1 without reaching RELEASE.
    - `retry_cnt` increments.
    - If the new value equals MAX_RETRIES → FAIL; otherwise → RESET_PLL.
  - RELEASE:
    - Outputs: `sdram_rst`=0, `cam_rst`=1.
    - After STAGGER_CYCLES cycles → RUN.
  - RUN:
    - Outputs: `sdram_rst`=0, `cam_rst`=0, `ready`=1.
    - `retry_cnt` clears to 0 on entry.
  - Lock loss in RELEASE or RUN (`lock_s`=0):
    - Next state is RESET_PLL, so all resets reassert on the next cycle.
    - `lock_loss_cnt` increments, saturating at 255.
  - FAIL:
    - Outputs: `pll_rst`=1, all downstream resets high, `fail`=1, `ready`=0.
    - Exits only on `rst` or `relock_req`.
- `relock_req`:
  - Accepted in any state.
  - Next state is RESET_PLL; `retry_cnt` clears; `fail` clears.
  - `lock_loss_cnt` is not incremented.
- Priority: `rst` > `relock_req` > lock loss > timeout > counter expiry.
- `rst` mid-sequence: everything returns to reset values on the next edge, regardless of state.
- Counter widths: `$clog2` of the largest parameter, plus 1. Compares are equality only.

Decomposition:
- Package `sdram_pll_seq_pkg`:
  - state enum (RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL);
  - `RETRY_W`=4, `LOSS_W`=8.
- One sub-module, `sync_2ff`: a 1-bit two-flop synchronizer clocked by `refclk` and reset by `rst`.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=5, MAX_RETRIES=3.
1. `pll_locked` rises at cycle 10 and stays high → `pll_rst`=1 for cycles 0–3; STABLE at 13; `sdram_rst`=0 from cycle 21; `cam_rst`=0 and `ready`=1 from cycle 26.
2. `pll_locked` held 0 → RESET_PLL at cycles 104 and 208 (`retry_cnt` 1, then 2); FAIL at cycle 312 with `fail`=1, `pll_rst`=1, `retry_cnt`=3.
3. `pll_locked` toggles every 6 cycles → never reaches RELEASE; times out every 104 cycles; FAIL at cycle 312.
4. From RUN, drop `pll_locked` for 1 cycle → 2 cycles later, `sdram_rst`/`cam_rst`=1 and `ready`=0 on the next edge; `lock_loss_cnt`=1; full re-sequence follows.
5. In FAIL, pulse `relock_req` → `fail`=0, `retry_cnt`=0, `pll_rst`=1 for 4 cycles, then normal bring-up.
6. Assert `rst` for 1 cycle in STABLE, and separately in RUN → all outputs return to reset values on the next edge.
